// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Holds the loader state encoding and the image framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Purpose: packs a big-endian byte stream into 32-bit words (8-to-32 shift register).
// Latency: word complete in the cycle after the 4th shift; full flag marks it.
// Backpressure: none of its own; shifts only when the loader accepts a byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o,
    output logic        full_o
);

    logic [31:0]           word_q;
    logic [BYTE_IDX_W-1:0] idx_q;
    logic                  full_q;

    // The byte being shifted now is the final one of the word.
    assign last_o = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word_o = word_q;
    assign full_o = full_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], byte_i};
            idx_q  <= idx_q + BYTE_IDX_W'(1);
            full_q <= last_o;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Purpose: loads a length-prefixed big-endian program image into imem, holding the CPU in reset.
// Latency: one write per 5 cycles with continuous input; DONE 2+5N cycles after first byte.
// Backpressure: byte_ready_o drops for the WRITE cycle and in DONE/ERR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic        reload_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        cpu_rst_n_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        hdr_hi_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [ADDR_W:0]   word_idx_inc;
    logic [31:0]       addr_q;
    logic [31:0]       data_hold_q;
    logic [15:0]       n_hdr;
    logic              hs;
    logic              asm_clr;
    logic              asm_shift;
    logic [31:0]       asm_word;
    logic              asm_last;
    logic              asm_full;

    assign byte_ready_o = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    assign busy_o       = byte_ready_o || (state_q == WRITE);
    assign imem_we_o    = (state_q == WRITE);
    assign cpu_rst_n_o  = (state_q == DONE);
    assign err_o        = (state_q == ERR);

    assign hs           = byte_valid_i && byte_ready_o;
    assign n_hdr        = {hdr_hi_q, byte_data_i};
    assign word_idx_inc = word_idx_q + (ADDR_W + 1)'(1);
    assign asm_clr      = (state_q == HDR_LO);
    assign asm_shift    = (state_q == DATA) && hs;

    word_assembler u_asm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (asm_clr),
        .shift_i (asm_shift),
        .byte_i  (byte_data_i),
        .word_o  (asm_word),
        .last_o  (asm_last),
        .full_o  (asm_full)
    );

    // The assembler starts shifting the next word right after WRITE, so the
    // data output switches to a held copy once the fresh word is gone.
    assign imem_data_o = asm_full ? asm_word : data_hold_q;
    assign imem_addr_o = addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: if (hs) state_d = HDR_LO;
            HDR_LO: begin
                if (hs) begin
                    if (n_hdr == 16'd0)                state_d = DONE;
                    else if ({1'b0, n_hdr} > CAPACITY) state_d = ERR;
                    else                               state_d = DATA;
                end
            end
            DATA:   if (hs && asm_last) state_d = WRITE;
            WRITE:  state_d = (word_idx_inc == n_q) ? DONE : DATA;
            DONE:   if (reload_i) state_d = HDR_HI;
            ERR:    state_d = ERR;
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hdr_hi_q    <= '0;
            n_q         <= '0;
            word_idx_q  <= '0;
            addr_q      <= '0;
            data_hold_q <= '0;
        end else begin
            if (state_q == HDR_HI && hs) begin
                hdr_hi_q <= byte_data_i;
            end
            if (state_q == HDR_LO && hs) begin
                n_q        <= n_hdr[ADDR_W:0];
                word_idx_q <= '0;
            end
            // Address is latched with the final byte so it is stable through
            // WRITE and holds after word_idx advances.
            if (asm_shift && asm_last) begin
                addr_q <= 32'({word_idx_q[ADDR_W-1:0], 2'b00});
            end
            if (state_q == WRITE) begin
                word_idx_q  <= word_idx_inc;
                data_hold_q <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of whole images plus hand sequences
// for capacity fill, error lock, mid-load reset and reload.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int hs_cnt = 0;
    int ready_in_write = 0;
    int first_hs = -1;
    int done_cyc = -1;

    imem_loader #(.ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .reload_i     (reload),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .cpu_rst_n_o  (cpu_rst_n),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
            if (byte_ready) ready_in_write++;
        end
        if (byte_valid && byte_ready && !rst) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
        end
        if (cpu_rst_n && done_cyc < 0) done_cyc = cyc;
    end

    typedef struct packed {
        logic [95:0] img;
        logic [7:0]  nb;
        logic        toggle;
        logic [1:0]  nw;
        logic [31:0] wa0;
        logic [31:0] wd0;
        logic [31:0] wa1;
        logic [31:0] wd1;
        logic        run;
        logic        err;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        hs_cnt = 0;
        ready_in_write = 0;
        first_hs = -1;
        done_cyc = -1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        reload = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Present a byte until it is accepted; bounded so a stuck ready cannot hang the run.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data = b;
        @(negedge clk);
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: byte %h not accepted within %0d cycles", b, t);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8]);
    endtask

    function automatic logic [31:0] wr_at(input int j, input bit is_addr);
        if (j >= wr_addr_q.size()) return 32'hxxxxxxxx;
        return is_addr ? wr_addr_q[j] : wr_data_q[j];
    endfunction

    initial begin
        vecs[0] = '{img: 96'h0002_1234_5678_9ABC_DEF0_0000, nb: 8'd10, toggle: 1'b0, nw: 2'd2,
                    wa0: 32'h0, wd0: 32'h12345678, wa1: 32'h4, wd1: 32'h9ABCDEF0, run: 1'b1, err: 1'b0};
        vecs[1] = '{img: 96'h0002_1234_5678_9ABC_DEF0_0000, nb: 8'd10, toggle: 1'b1, nw: 2'd2,
                    wa0: 32'h0, wd0: 32'h12345678, wa1: 32'h4, wd1: 32'h9ABCDEF0, run: 1'b1, err: 1'b0};
        vecs[2] = '{img: 96'h0000_0000_0000_0000_0000_0000, nb: 8'd2, toggle: 1'b0, nw: 2'd0,
                    wa0: 32'h0, wd0: 32'h0, wa1: 32'h0, wd1: 32'h0, run: 1'b1, err: 1'b0};
        vecs[3] = '{img: 96'h0101_0000_0000_0000_0000_0000, nb: 8'd2, toggle: 1'b0, nw: 2'd0,
                    wa0: 32'h0, wd0: 32'h0, wa1: 32'h0, wd1: 32'h0, run: 1'b0, err: 1'b1};

        apply_reset();
        chk("rst_ready", {31'b0, byte_ready}, 32'd1);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_data", imem_data, 32'h0);
        chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_err", {31'b0, err}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            apply_reset();
            clear_mon();
            for (int i = 0; i < int'(vecs[v].nb); i++) begin
                send_byte(vecs[v].img[95 - 8*i -: 8]);
                if (vecs[v].toggle) step(1);
            end
            step(3);
            chk($sformatf("v%0d_wr_count", v), 32'(wr_addr_q.size()), 32'(vecs[v].nw));
            if (vecs[v].nw >= 2'd1) begin
                chk($sformatf("v%0d_addr0", v), wr_at(0, 1), vecs[v].wa0);
                chk($sformatf("v%0d_data0", v), wr_at(0, 0), vecs[v].wd0);
            end
            if (vecs[v].nw >= 2'd2) begin
                chk($sformatf("v%0d_addr1", v), wr_at(1, 1), vecs[v].wa1);
                chk($sformatf("v%0d_data1", v), wr_at(1, 0), vecs[v].wd1);
            end
            chk($sformatf("v%0d_cpu_rst_n", v), {31'b0, cpu_rst_n}, {31'b0, vecs[v].run});
            chk($sformatf("v%0d_err", v), {31'b0, err}, {31'b0, vecs[v].err});
            chk($sformatf("v%0d_busy", v), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_ready_end", v), {31'b0, byte_ready}, 32'd0);
            chk($sformatf("v%0d_bytes_taken", v), 32'(hs_cnt), 32'(vecs[v].nb));
            if (v == 0)
                chk("v0_done_latency", 32'(done_cyc - first_hs), 32'(HDR_BYTES + 5 * 2));
            if (vecs[v].toggle)
                chk($sformatf("v%0d_ready_in_write", v), 32'(ready_in_write), 32'd0);
        end

        // Still in ERR from the last vector: reload and bytes must be ignored.
        clear_mon();
        reload = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h55;
        step(1);
        reload = 1'b0;
        step(4);
        byte_valid = 1'b0;
        chk("err_hold_err", {31'b0, err}, 32'd1);
        chk("err_hold_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("err_hold_writes", 32'(wr_addr_q.size()), 32'd0);
        chk("err_hold_bytes", 32'(hs_cnt), 32'd0);

        // Full capacity: 256 words fill 0x000..0x3FC.
        apply_reset();
        clear_mon();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int w = 0; w < 256; w++) send_word(32'hA5000000 + 32'(w * 3));
        step(3);
        chk("fill_wr_count", 32'(wr_addr_q.size()), 32'd256);
        for (int w = 0; w < 256; w++) begin
            chk($sformatf("fill_addr%0d", w), wr_at(w, 1), 32'(w * 4));
            chk($sformatf("fill_data%0d", w), wr_at(w, 0), 32'hA5000000 + 32'(w * 3));
        end
        chk("fill_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);
        chk("fill_err", {31'b0, err}, 32'd0);

        // Reset part-way through the first data word; partial bytes must not leak.
        apply_reset();
        clear_mon();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd1);
        chk("midrst_ready", {31'b0, byte_ready}, 32'd1);
        clear_mon();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        step(3);
        chk("midrst_wr_count", 32'(wr_addr_q.size()), 32'd1);
        chk("midrst_addr0", wr_at(0, 1), 32'h0);
        chk("midrst_data0", wr_at(0, 0), 32'hDEADBEEF);
        chk("midrst_cpu_rst_n_end", {31'b0, cpu_rst_n}, 32'd1);

        // Reload from DONE.
        clear_mon();
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        chk("reload_cpu_rst_n_drop", {31'b0, cpu_rst_n}, 32'd0);
        chk("reload_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hCA);
        send_byte(8'hFE);
        chk("reload_cpu_rst_n_mid", {31'b0, cpu_rst_n}, 32'd0);
        send_byte(8'hF0);
        send_byte(8'h0D);
        step(3);
        chk("reload_wr_count", 32'(wr_addr_q.size()), 32'd1);
        chk("reload_addr0", wr_at(0, 1), 32'h0);
        chk("reload_data0", wr_at(0, 0), 32'hCAFEF00D);
        chk("reload_cpu_rst_n_end", {31'b0, cpu_rst_n}, 32'd1);
        chk("reload_data_hold", imem_data, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the other side of the CPU's instruction-fetch path. It receives a program image as a byte stream with a valid/ready handshake and assembles big-endian 32-bit words. It writes each word into instruction memory at consecutive word addresses starting at 0. While loading, it holds the CPU in reset; it releases the CPU once the last word is written.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- byte_valid_i  in  1  source has a byte on byte_data_i
- byte_data_i  in  8  stream byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- reload_i  in  1  single-cycle request to load a new image (honoured only in DONE)
- imem_we_o  out  1  instruction-memory write strobe, one cycle per word
- imem_addr_o  out  32  byte address of the write, always word aligned (bits [1:0]=0)
- imem_data_o  out  32  word to write
- cpu_rst_n_o  out  1  CPU reset, low while loading, high only in DONE
- busy_o  out  1  high in HDR_HI, HDR_LO, DATA, WRITE
- err_o  out  1  header word count exceeds capacity

## Operation
- Image format: 16-bit word count N (high byte first), then N words of 4 bytes each, most-significant byte first.
- A byte transfers when byte_valid_i && byte_ready_o on a rising edge.
- byte_ready_o = 1 in HDR_HI, HDR_LO and DATA; 0 in WRITE, DONE and ERR.
- HDR_HI: capture N[15:8], go to HDR_LO.
- HDR_LO: capture N[7:0]. Then:
  - if N==0, go to DONE;
  - if N > 2^ADDR_W, go to ERR;
  - otherwise clear the byte index and word index and go to DATA.
- DATA: shift the byte into the assembly register, data = {data[23:0], byte}. Increment the 2-bit byte index. On the 4th byte, go to WRITE.
- WRITE: imem_we_o=1, imem_addr_o={word_idx,2'b00} zero-extended to 32 bits, imem_data_o=assembled word. Then increment word_idx. If word_idx+1 == N, go to DONE; otherwise go to DATA.
- DONE: cpu_rst_n_o=1. reload_i goes to HDR_HI, and cpu_rst_n_o drops in the same cycle the state changes. Input bytes are ignored.
- ERR: err_o=1, cpu_rst_n_o=0, no writes, no bytes accepted, reload_i ignored. Only rst_i exits ERR.
- Word index and N comparison use ADDR_W+1 bits, so N = 2^ADDR_W exactly is legal and fills memory. Address never wraps.
- byte_valid_i is ignored whenever byte_ready_o=0. No byte is lost or duplicated across the WRITE stall.

## Timing
- Reset values: state HDR_HI, byte_ready_o=1, imem_we_o=0, imem_addr_o=0, imem_data_o=0, cpu_rst_n_o=0, busy_o=1, err_o=0. Internal N, indices and assembly register are all 0.
- cpu_rst_n_o, busy_o, err_o and byte_ready_o are decoded from the registered state only. They are glitch-free and have no combinational path from inputs.
- imem_we_o is asserted the cycle after the 4th byte handshake, for exactly one cycle. imem_addr_o and imem_data_o are valid in that cycle and hold until the next write.
- Throughput with continuous valid: 5 cycles per word. Total load time = 2 + 5N cycles from the first handshake to entering DONE.
- cpu_rst_n_o rises in the cycle after the last WRITE, so the CPU fetches address 0 with the full image present.
- rst_i mid-load returns to HDR_HI and lowers cpu_rst_n_o immediately; any partial word is discarded. rst_i takes priority over reload_i and handshakes in the same cycle.

## Structure
- Package imem_loader_pkg holds:
  - state enum: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR;
  - the header byte-count constant (2) and bytes-per-word constant (4).
- One natural sub-module, word_assembler: an 8-to-32 shift register with 2-bit byte index and a full flag, cleared by the loader. Everything else (FSM, counters, N register) stays in imem_loader.

## Test plan
- N=2, bytes 00 02 | 12 34 56 78 | 9A BC DE F0 with continuous valid. Expect writes (0x0,0x12345678) then (0x4,0x9ABCDEF0), cpu_rst_n_o=1 at cycle 12 after the first handshake, and exactly 2 write strobes.
- Same image with valid toggling every other cycle. Expect identical writes, and byte_ready_o=0 during both WRITE cycles with no bytes consumed there.
- Header 00 00. Expect DONE immediately after the header, no imem_we_o, cpu_rst_n_o=1.
- ADDR_W=8: header 01 00 plus 256 words must fill addresses 0x000..0x3FC. Header 01 01 must give err_o=1, no writes, cpu_rst_n_o held 0, and reload_i ignored.
- Assert rst_i after 2 of 4 bytes of word 1. Expect return to HDR_HI and cpu_rst_n_o=0. A fresh N=1 image DEADBEEF then writes (0x0,0xDEADBEEF), with no residue of the partial word.
- In DONE, pulse reload_i and send 00 01 CAFEF00D. Expect cpu_rst_n_o low during the reload, a write of (0x0,0xCAFEF00D), then cpu_rst_n_o high again.
